seq_multiplier: RTL and testbench

Parametrised sequential shift-add multiplier that generalises the team's 4x4 array multiplier to WIDTH x WIDTH operands. Each operation selects unsigned or two's-complement mode. Operands are accepted through a start/busy/done handshake. One adder is reused for WIDTH cycles instead of a WIDTH^2 adder array, so the block suits datapaths where area matters more than single-cycle latency.

---
 rtl/seq_multiplier.sv | 121 ++++++++++++
 tb/tb_seq_multiplier.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one WIDTH+1 bit adder reused over WIDTH cycles,
// unsigned or two's-complement per operation, start/busy/done handshake.
`timescale 1ns/1ps
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  // Handshake: start is sampled only while busy=0 (state IDLE); done is a
  // one-cycle pulse with product already valid; product holds until the next done.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH:0]     acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH:0]     acc_sum;
  logic [2*WIDTH-1:0]   acc_low;

  // The magnitude of the most-negative value, 2^(WIDTH-1), still fits unsigned in WIDTH bits.
  always_comb begin
    a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
    b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;
  end

  // acc_q[2*WIDTH] is always 0 after a shift, so the WIDTH+1 bit sum keeps the carry.
  always_comb begin
    sum     = acc_q[2*WIDTH:WIDTH] + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_sum = {sum, acc_q[WIDTH-1:0]};
    acc_low = acc_q[2*WIDTH-1:0];
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    done_d    = 1'b0;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = acc_sum >> 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        product_d = neg_q ? -acc_low : acc_low;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: WIDTH=4 and WIDTH=8 instances, table vectors, exhaustive
// and random back-to-back operations against an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start4 = 1'b0, s4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4;
  logic [7:0] product4;

  logic       start8 = 1'b0, s8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8;
  logic [15:0] product8;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          w;
    bit          s;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(s4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(product4)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(s8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8)
  );

  // Reference: interpret operands as integers, multiply, keep the low 2*w bits.
  function automatic logic [15:0] model(input int w, input bit s, input logic [7:0] a,
                                        input logic [7:0] b);
    longint av, bv, p, mask;
    av = longint'(a) & ((longint'(1) << w) - 1);
    bv = longint'(b) & ((longint'(1) << w) - 1);
    if (s && av >= (longint'(1) << (w - 1))) av = av - (longint'(1) << w);
    if (s && bv >= (longint'(1) << (w - 1))) bv = bv - (longint'(1) << w);
    p    = av * bv;
    mask = (longint'(1) << (2 * w)) - 1;
    return 16'(p & mask);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input int w, input bit st, input bit s, input logic [7:0] a,
                       input logic [7:0] b);
    if (w == 4) begin
      start4 = st; s4 = s; a4 = a[3:0]; b4 = b[3:0];
    end else begin
      start8 = st; s8 = s; a8 = a; b8 = b;
    end
  endtask

  function automatic bit rd_busy(input int w);
    return (w == 4) ? busy4 : busy8;
  endfunction

  function automatic bit rd_done(input int w);
    return (w == 4) ? done4 : done8;
  endfunction

  function automatic logic [15:0] rd_product(input int w);
    return (w == 4) ? {8'h00, product4} : product8;
  endfunction

  // Present one operation, wait for done, check product, latency and busy length.
  // Returns #1 after the edge that raised done, so the next call lands in the done cycle.
  task automatic run_op(input int w, input bit s, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input bit hammer, input string tag);
    int edges;
    int busy_cnt;
    bit seen;
    drive(w, 1'b1, s, a, b);
    @(posedge clk); #1;
    edges = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && edges < 4 * w + 10) begin
      if (hammer && edges < w - 1)
        drive(w, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      else
        drive(w, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      if (rd_busy(w)) busy_cnt++;
      if (rd_done(w)) begin
        seen = 1'b1;
      end else begin
        @(posedge clk); #1;
        edges++;
      end
    end
    if (!seen) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_product"}, 32'(rd_product(w)), 32'(exp));
      check({tag, "_latency"}, 32'(edges), 32'(w + 1));
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(w + 1));
    end
  endtask

  initial begin
    int done_seen;
    logic [7:0] ra, rb;
    bit rs;

    vecs.push_back('{4, 1'b0, 8'h0F, 8'h0F, 16'h00E1});
    vecs.push_back('{4, 1'b1, 8'h08, 8'h08, 16'h0040});
    vecs.push_back('{4, 1'b1, 8'h08, 8'h07, 16'h00C8});
    vecs.push_back('{4, 1'b1, 8'h0F, 8'h0F, 16'h0001});
    vecs.push_back('{4, 1'b0, 8'h00, 8'h09, 16'h0000});
    vecs.push_back('{4, 1'b0, 8'h09, 8'h00, 16'h0000});
    vecs.push_back('{4, 1'b1, 8'h00, 8'h0A, 16'h0000});
    vecs.push_back('{4, 1'b1, 8'h0A, 8'h00, 16'h0000});
    vecs.push_back('{8, 1'b0, 8'hFF, 8'hFF, 16'hFE01});
    vecs.push_back('{8, 1'b1, 8'h80, 8'hFF, 16'h0080});
    vecs.push_back('{8, 1'b1, 8'h80, 8'h80, 16'h4000});
    vecs.push_back('{8, 1'b1, 8'h7F, 8'h80, 16'hC080});
    vecs.push_back('{8, 1'b0, 8'h00, 8'h55, 16'h0000});
    vecs.push_back('{8, 1'b1, 8'hC3, 8'h00, 16'h0000});

    repeat (3) @(negedge clk);
    check("reset_busy4", 32'(busy4), 32'd0);
    check("reset_done4", 32'(done4), 32'd0);
    check("reset_product4", 32'(product4), 32'd0);
    check("reset_busy8", 32'(busy8), 32'd0);
    check("reset_product8", 32'(product8), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].w, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0,
             $sformatf("vec%0d", i));
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), 32'(rd_done(vecs[i].w)), 32'd0);
    end

    // Start held high with other operands while busy must not disturb the result.
    run_op(8, 1'b0, 8'h12, 8'h34, 16'h03A8, 1'b1, "busy_ignore_u");
    run_op(8, 1'b1, 8'hF6, 8'h05, 16'hFFCE, 1'b1, "busy_ignore_s");
    @(posedge clk); #1;

    // Exhaustive WIDTH=4, back-to-back: each start is raised in the previous done cycle.
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          run_op(4, 1'(m), 8'(x), 8'(y), model(4, 1'(m), 8'(x), 8'(y)), 1'b0,
                 $sformatf("ex_m%0d_a%0d_b%0d", m, x, y));
        end
      end
    end
    @(posedge clk); #1;

    for (int i = 0; i < 120; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom_range(0, 1));
      run_op(8, rs, ra, rb, model(8, rs, ra, rb), 1'($urandom_range(0, 1)),
             $sformatf("rnd%0d_s%0d_%0h_%0h", i, rs, ra, rb));
    end
    @(posedge clk); #1;

    // Asynchronous reset in the middle of CALC discards the operation.
    run_op(4, 1'b0, 8'h07, 8'h09, 16'h003F, 1'b0, "pre_reset");
    @(posedge clk); #1;
    drive(4, 1'b1, 1'b0, 8'h05, 8'h06);
    @(posedge clk); #1;
    drive(4, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy4), 32'd0);
    check("async_rst_done", 32'(done4), 32'd0);
    check("async_rst_product", 32'(product4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done4 || busy4) done_seen++;
    end
    check("no_done_after_rst", 32'(done_seen), 32'd0);
    run_op(4, 1'b0, 8'h03, 8'h05, 16'h000F, 1'b0, "post_reset");
    @(posedge clk); #1;
    check("post_reset_hold", 32'(product4), 32'h0F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
